// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT-side frame loader.
// Provides the data width default, read FSM states and frame length clamp.
package fft_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LAST  = 2'd2
  } rd_state_e;

  // 1 << min(fs, aw)
  function automatic logic [31:0] frame_len(
    input logic [3:0]  fs,
    input int unsigned aw
  );
    int unsigned sh;
    sh = {28'd0, fs};
    if (sh > aw) sh = aw;
    return 32'd1 << sh;
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// FFT core / arbiter bundle seen by the frame loader.
// master: drives samples, grant, config; slave: the loader itself.
interface fft_frame_loader_if
  import fft_pkg::*;
#(
  parameter int DATA_W = fft_pkg::DATA_W
);

  logic [3:0]        frameSize;
  logic [DATA_W-1:0] fftSample;
  logic              fftSampleValid;
  logic              fftMemReady;
  logic              clrOverflow;
  logic              fftFrameReady;
  logic [DATA_W-1:0] fftDout;
  logic              fftDoutValid;
  logic              frameDone;
  logic              overflow;

  modport master (
    output frameSize, fftSample, fftSampleValid,
    output fftMemReady, clrOverflow,
    input  fftFrameReady, fftDout, fftDoutValid,
    input  frameDone, overflow
  );

  modport slave (
    input  frameSize, fftSample, fftSampleValid,
    input  fftMemReady, clrOverflow,
    output fftFrameReady, fftDout, fftDoutValid,
    output frameDone, overflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO, registered read port, full/empty flags.
// Ports: i_wr/i_wdata push, i_rd pop (data next cycle on o_rdata).
module sync_fifo_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [DW-1:0] r_rdata;
  logic          w_full;
  logic          w_empty;
  logic          w_we;
  logic          w_re;

  // extra MSB tells a full wrap from empty
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_we    = i_wr && !w_full;
  assign w_re    = i_rd && !w_empty;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_we) r_wptr <= r_wptr + 1'b1;
      if (w_re) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr[AW-1:0]];
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/fft_frame_loader.sv
// Buffers FFT output into frames of 2^frameSize words, drains to arbiter.
// Ports: CLK, RST_N, bus (slave side of fft_frame_loader_if).
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int MAXF   = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  fft_frame_loader_if.slave  bus
);

  localparam int LW = ADDR_W + 1;
  localparam int PW = $clog2(MAXF + 1);

  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_rdata;
  logic [LW-1:0]     r_len;
  logic [LW-1:0]     w_len;
  logic [LW-1:0]     w_len_m1;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic [PW-1:0]     r_pend;
  logic [PW-1:0]     w_pend_nxt;
  rd_state_e         r_state;
  logic              r_ready;
  logic              r_valid;
  logic              r_done;
  logic              r_ovf;
  logic              w_latch;
  logic              w_wr;
  logic              w_drop;
  logic              w_wr_last;
  logic              w_pop;
  logic              w_rd_last;

  // new length applies in the latching cycle itself,
  // so the first write of a frame compares against it
  assign w_latch   = w_empty && (r_wr_cnt == '0) &&
                     (r_state == IDLE);
  assign w_len     = w_latch ?
                     LW'(frame_len(bus.frameSize, ADDR_W)) :
                     r_len;
  assign w_len_m1  = w_len - 1'b1;

  assign w_wr      = bus.fftSampleValid && !w_full;
  assign w_drop    = bus.fftSampleValid && w_full;
  assign w_wr_last = w_wr && ({1'b0, r_wr_cnt} == w_len_m1);
  assign w_pop     = (r_state == DRAIN) && bus.fftMemReady;
  assign w_rd_last = w_pop && ({1'b0, r_rd_cnt} == w_len_m1);

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_last && !w_rd_last) begin
      if (r_pend != PW'(MAXF)) w_pend_nxt = r_pend + 1'b1;
    end else if (!w_wr_last && w_rd_last) begin
      w_pend_nxt = r_pend - 1'b1;
    end
  end

  sync_fifo_ram #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_wr    (w_wr),
    .i_wdata (bus.fftSample),
    .i_rd    (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_len    <= LW'(1);
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_pend   <= '0;
      r_state  <= IDLE;
      r_ready  <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_latch) r_len <= w_len;
      if (w_wr) begin
        r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
      end
      r_pend  <= w_pend_nxt;
      r_ready <= (w_pend_nxt != '0);
      r_valid <= w_pop;
      r_done  <= w_rd_last;
      if (w_drop)               r_ovf <= 1'b1;
      else if (bus.clrOverflow) r_ovf <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if ((r_pend != '0) && bus.fftMemReady) begin
            r_state  <= DRAIN;
            r_rd_cnt <= '0;
          end
        end
        DRAIN: begin
          if (w_pop) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_rd_last) r_state <= LAST;
          end
        end
        LAST:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.fftFrameReady = r_ready;
  assign bus.fftDout       = w_rdata;
  assign bus.fftDoutValid  = r_valid;
  assign bus.frameDone     = r_done;
  assign bus.overflow      = r_ovf;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: DUT A (ADDR_W=10), DUT B (4).
// Expected words queued at stimulus time; a monitor pops on fftDoutValid.
module tb_fft_frame_loader;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_frame_loader_if #(.DATA_W(16)) ifa ();
  fft_frame_loader_if #(.DATA_W(16)) ifb ();

  fft_frame_loader #(
    .ADDR_W (10), .DATA_W (16), .MAXF (3)
  ) dut_a (
    .CLK (clk), .RST_N (rst_n), .bus (ifa.slave)
  );

  fft_frame_loader #(
    .ADDR_W (4), .DATA_W (16), .MAXF (3)
  ) dut_b (
    .CLK (clk), .RST_N (rst_n), .bus (ifb.slave)
  );

  int checks = 0;
  int fails  = 0;
  logic [16:0] qa[$];
  logic [16:0] qb[$];
  logic pra = 1'b0;
  logic prb = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic idle_inputs();
    ifa.frameSize = 4'd0; ifa.fftSample = '0;
    ifa.fftSampleValid = 1'b0; ifa.fftMemReady = 1'b0;
    ifa.clrOverflow = 1'b0;
    ifb.frameSize = 4'd0; ifb.fftSample = '0;
    ifb.fftSampleValid = 1'b0; ifb.fftMemReady = 1'b0;
    ifb.clrOverflow = 1'b0;
  endtask

  task automatic send(input bit b, input int first,
                      input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk); #1;
      if (b) begin
        ifb.fftSample = 16'(first + i);
        ifb.fftSampleValid = 1'b1;
      end else begin
        ifa.fftSample = 16'(first + i);
        ifa.fftSampleValid = 1'b1;
      end
    end
    @(posedge clk); #1;
    ifa.fftSampleValid = 1'b0;
    ifb.fftSampleValid = 1'b0;
  endtask

  task automatic expect_words(input bit b, input int first,
                              input int count, input int n);
    logic [16:0] e;
    for (int i = 0; i < count; i++) begin
      e = {((i + 1) % n == 0), 16'(first + i)};
      if (b) qb.push_back(e);
      else   qa.push_back(e);
    end
  endtask

  task automatic wait_empty(input int budget);
    int k;
    k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_complete", 32'(qa.size() + qb.size()), 0);
  endtask

  task automatic mon(input bit b, input logic v, input logic d,
                     input logic [15:0] q, input logic pr);
    logic [16:0] e;
    if (v) begin
      chk(b ? "B_grant_before_valid" : "A_grant_before_valid",
          32'(pr), 1);
      if ((b ? qb.size() : qa.size()) == 0) begin
        checks++;
        fails++;
        $display("FAIL %s unexpected word actual=%0h required=none",
                 b ? "B_word" : "A_word", q);
      end else begin
        e = b ? qb.pop_front() : qa.pop_front();
        chk(b ? "B_data" : "A_data", 32'(q), 32'(e[15:0]));
        chk(b ? "B_frameDone" : "A_frameDone", 32'(d), 32'(e[16]));
      end
    end else if (d) begin
      chk(b ? "B_done_no_valid" : "A_done_no_valid", 32'(d), 0);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon(1'b0, ifa.fftDoutValid, ifa.frameDone, ifa.fftDout, pra);
        mon(1'b1, ifb.fftDoutValid, ifb.frameDone, ifb.fftDout, prb);
      end
      pra = ifa.fftMemReady;
      prb = ifb.fftMemReady;
    end
  endtask

  task automatic run();
    // single frame of 8, grant held
    ifa.frameSize = 4'd3; ifa.fftMemReady = 1'b1;
    expect_words(1'b0, 1, 8, 8);
    send(1'b0, 1, 7);
    chk("A_ready_before_8th", 32'(ifa.fftFrameReady), 0);
    send(1'b0, 8, 1);
    chk("A_ready_after_8th", 32'(ifa.fftFrameReady), 1);
    wait_empty(100);
    chk("A_ready_fall", 32'(ifa.fftFrameReady), 0);

    // three frames of 4 back to back
    ifa.frameSize = 4'd2;
    expect_words(1'b0, 'h10, 12, 4);
    send(1'b0, 'h10, 12);
    wait_empty(200);
    chk("A_ready_after_3", 32'(ifa.fftFrameReady), 0);

    // stalled drain 1,0,0,1,0,0...
    ifa.frameSize = 4'd3; ifa.fftMemReady = 1'b0;
    expect_words(1'b0, 'h20, 8, 8);
    send(1'b0, 'h20, 8);
    for (int c = 0; c < 48; c++) begin
      @(posedge clk); #1;
      ifa.fftMemReady = (c % 3 == 0);
    end
    ifa.fftMemReady = 1'b1;
    wait_empty(100);

    // overflow on the 16-deep FIFO
    ifb.frameSize = 4'd4; ifb.fftMemReady = 1'b0;
    expect_words(1'b1, 'h40, 16, 16);
    send(1'b1, 'h40, 17);
    chk("B_overflow_set", 32'(ifb.overflow), 1);
    chk("B_ready_full", 32'(ifb.fftFrameReady), 1);
    @(posedge clk); #1;
    ifb.fftSample = 16'hdead;
    ifb.fftSampleValid = 1'b1;
    ifb.clrOverflow = 1'b1;
    @(posedge clk); #1;
    ifb.fftSampleValid = 1'b0;
    chk("B_overflow_priority", 32'(ifb.overflow), 1);
    @(posedge clk); #1;
    ifb.clrOverflow = 1'b0;
    chk("B_overflow_clear", 32'(ifb.overflow), 0);
    ifb.fftMemReady = 1'b1;
    wait_empty(100);

    // frameSize clamps to ADDR_W
    ifb.frameSize = 4'd15;
    expect_words(1'b1, 'h60, 16, 16);
    send(1'b1, 'h60, 16);
    wait_empty(100);
    chk("B_ready_after_clamp", 32'(ifb.fftFrameReady), 0);

    // frameSize change mid-frame
    ifa.frameSize = 4'd3; ifa.fftMemReady = 1'b1;
    expect_words(1'b0, 'h80, 8, 8);
    send(1'b0, 'h80, 4);
    ifa.frameSize = 4'd5;
    send(1'b0, 'h84, 4);
    wait_empty(100);
    expect_words(1'b0, 'h100, 32, 32);
    send(1'b0, 'h100, 32);
    wait_empty(200);

    // frameSize 0: every word is a frame
    ifa.frameSize = 4'd0;
    expect_words(1'b0, 'h200, 3, 1);
    send(1'b0, 'h200, 3);
    wait_empty(100);

    // reset in the middle of a drain
    ifa.frameSize = 4'd3;
    expect_words(1'b0, 'h300, 8, 8);
    send(1'b0, 'h300, 8);
    repeat (3) @(posedge clk);
    #2;
    chk("A_mid_drain_valid", 32'(ifa.fftDoutValid), 1);
    rst_n = 1'b0;
    #1;
    chk("A_rst_valid", 32'(ifa.fftDoutValid), 0);
    chk("A_rst_dout", 32'(ifa.fftDout), 0);
    chk("A_rst_ready", 32'(ifa.fftFrameReady), 0);
    chk("A_rst_done", 32'(ifa.frameDone), 0);
    chk("A_rst_ovf", 32'(ifa.overflow), 0);
    qa.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_words(1'b0, 'h400, 8, 8);
    send(1'b0, 'h400, 8);
    wait_empty(100);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_A_valid", 32'(ifa.fftDoutValid), 0);
    chk("rst_A_ready", 32'(ifa.fftFrameReady), 0);
    chk("rst_A_dout", 32'(ifa.fftDout), 0);
    chk("rst_A_done", 32'(ifa.frameDone), 0);
    chk("rst_B_ovf", 32'(ifb.overflow), 0);
    rst_n = 1'b1;
    fork
      monitor();
      run();
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
